// File: rtl/quotient_select_div.sv
// quotient_select_div: picks a quotient digit in {-1,0,+1} and streams -q*D chunks to the residue datapath.
// Optional QSEL_SAT_EN: overflow saturates q and pulses error_flag instead of aborting.
module quotient_select_div #(
  parameter int UNROLLING  = 4,
  parameter int UPPER_BITS = 6,
  parameter int RAM_width  = 7,
  parameter int CHUNKS     = 8,
  parameter int ITERATIONS = 32
) (
  input  logic                  clk,
  input  logic                  async_clear_n,
  input  logic                  start,
  input  logic [UPPER_BITS-1:0] res_upper_plus,
  input  logic [UPPER_BITS-1:0] res_upper_minus,
  input  logic [UNROLLING-1:0]  div_plus_chunk,
  input  logic [UNROLLING-1:0]  div_minus_chunk,
  output logic [RAM_width-1:0]  div_addr,
  output logic [UNROLLING-1:0]  d_plus_vec,
  output logic [UNROLLING-1:0]  d_minus_vec,
  output logic [1:0]            enable_d,
  output logic                  enable_cout,
  output logic [1:0]            en_shift,
  output logic [RAM_width-1:0]  write_addr,
  output logic [RAM_width-1:0]  read_addr,
  output logic                  q_plus,
  output logic                  q_minus,
  output logic                  q_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  error_flag
);

  localparam int EW = UPPER_BITS + 1;
  localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic signed [EW-1:0] Q_POS = EW'(8);
  localparam logic signed [EW-1:0] Q_NEG = EW'(-8);
  localparam logic signed [EW-1:0] O_POS = EW'(48);
  localparam logic signed [EW-1:0] O_NEG = EW'(-48);
  localparam logic [RAM_width-1:0] K_LAST = RAM_width'(CHUNKS - 2);
  localparam logic [RAM_width-1:0] K_FIN = RAM_width'(CHUNKS - 1);
  localparam logic [IW-1:0] I_LAST = IW'(ITERATIONS - 1);

  typedef enum logic [2:0] {
    IDLE, SELECT, STREAM, FINAL, DONE
  } state_t;

  state_t state;
  logic [IW-1:0] iter;
  logic q_p_r, q_m_r;
  logic sel_p, sel_m, ovf, abort;
  logic signed [EW-1:0] est;

  assign est = $signed({1'b0, res_upper_plus})
             - $signed({1'b0, res_upper_minus});
  assign ovf = (est >= O_POS) || (est <= O_NEG);

  always_comb begin
    sel_p = 1'b0;
    sel_m = 1'b0;
    unique case (1'b1)
      (est >= Q_POS): sel_p = 1'b1;
      (est < Q_NEG): sel_m = 1'b1;
      default: ;
    endcase
`ifndef QSEL_SAT_EN
    if (ovf) begin
      sel_p = 1'b0;
      sel_m = 1'b0;
    end
`endif
  end

`ifdef QSEL_SAT_EN
  assign abort = 1'b0;
`else
  assign abort = error_flag;
`endif

  // Digit is visible combinationally in SELECT so it lines up with q_valid
  assign q_plus = (state == SELECT) ? sel_p : q_p_r;
  assign q_minus = (state == SELECT) ? sel_m : q_m_r;
  assign div_addr = read_addr;

  always_comb begin
    d_plus_vec = '0;
    d_minus_vec = '0;
    if (enable_d != 2'd0) begin
      unique case (1'b1)
        q_p_r: begin
          d_plus_vec = div_minus_chunk;
          d_minus_vec = div_plus_chunk;
        end
        q_m_r: begin
          d_plus_vec = div_plus_chunk;
          d_minus_vec = div_minus_chunk;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge async_clear_n) begin
    if (!async_clear_n) begin
      state <= IDLE;
      iter <= '0;
      q_p_r <= 1'b0;
      q_m_r <= 1'b0;
      read_addr <= '0;
      write_addr <= '0;
      enable_d <= 2'd0;
      enable_cout <= 1'b0;
      en_shift <= 2'd0;
      q_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error_flag <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      done <= 1'b0;
      write_addr <= read_addr;
`ifdef QSEL_SAT_EN
      error_flag <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= SELECT;
            busy <= 1'b1;
            q_valid <= 1'b1;
            iter <= '0;
            error_flag <= 1'b0;
          end
        end
        SELECT: begin
          state <= STREAM;
          q_p_r <= sel_p;
          q_m_r <= sel_m;
          read_addr <= '0;
          enable_d <= 2'd1;
          en_shift <= 2'd1;
          enable_cout <= 1'b0;
          if (ovf) error_flag <= 1'b1;
        end
        STREAM: begin
          enable_cout <= 1'b1;
          if (read_addr == K_LAST) begin
            state <= FINAL;
            read_addr <= K_FIN;
            enable_d <= 2'd2;
            en_shift <= 2'd2;
          end else begin
            read_addr <= read_addr + RAM_width'(1);
          end
        end
        FINAL: begin
          read_addr <= '0;
          enable_d <= 2'd0;
          en_shift <= 2'd0;
          enable_cout <= 1'b0;
          if (abort || iter == I_LAST) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            state <= SELECT;
            iter <= iter + IW'(1);
            q_valid <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quotient_select_div.sv
// tb_quotient_select_div: random + directed stimulus against a
// cycle-schedule model of the digit selector.
module tb_quotient_select_div;

  localparam int UNR = 4;
  localparam int UB = 6;
  localparam int RW = 7;
  localparam int C = 8;
  localparam int IT = 32;
  localparam int PER = C + 1;
`ifdef QSEL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic async_clear_n = 1'b1;
  logic start = 1'b0;
  logic [UB-1:0] res_p = '0;
  logic [UB-1:0] res_m = '0;
  logic [UNR-1:0] div_p = '0;
  logic [UNR-1:0] div_m = '0;
  logic [RW-1:0] div_addr, write_addr, read_addr;
  logic [UNR-1:0] d_plus_vec, d_minus_vec;
  logic [1:0] enable_d, en_shift;
  logic enable_cout, q_plus, q_minus, q_valid;
  logic busy, done, error_flag;

  quotient_select_div #(
    .UNROLLING(UNR), .UPPER_BITS(UB), .RAM_width(RW),
    .CHUNKS(C), .ITERATIONS(IT)
  ) dut (
    .clk(clk), .async_clear_n(async_clear_n), .start(start),
    .res_upper_plus(res_p), .res_upper_minus(res_m),
    .div_plus_chunk(div_p), .div_minus_chunk(div_m),
    .div_addr(div_addr), .d_plus_vec(d_plus_vec),
    .d_minus_vec(d_minus_vec), .enable_d(enable_d),
    .enable_cout(enable_cout), .en_shift(en_shift),
    .write_addr(write_addr), .read_addr(read_addr),
    .q_plus(q_plus), .q_minus(q_minus), .q_valid(q_valid),
    .busy(busy), .done(done), .error_flag(error_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // stimulus controls and literal pins
  bit rnd = 1'b0;
  int lim = 40;
  bit pin_en = 1'b0;
  int pin_qp, pin_qm, pin_dp, pin_dm, pin_ndig, pin_lat;

  // model state
  int t = 0;
  int ndig = IT;
  int mqp = 0, mqm = 0;
  int err_vis = 0;
  int prev_ra = 0;
  int cyc = 0;
  int start_cyc = 0;
  int dqv = 0;

  always @(negedge clk) begin
    int p, j, est, tdone, ra, ed, es, co, qv, bz, dn, dp, dm;
    int eqp, eqm, ovf, err_next;
    cyc++;
    if (!async_clear_n) begin
      chk("rst_addr", int'(read_addr), 0);
      chk("rst_div_addr", int'(div_addr), 0);
      chk("rst_waddr", int'(write_addr), 0);
      chk("rst_en", int'({enable_d, en_shift, enable_cout}), 0);
      chk("rst_q", int'({q_plus, q_minus, q_valid}), 0);
      chk("rst_d", int'({d_plus_vec, d_minus_vec}), 0);
      chk("rst_flags", int'({busy, done, error_flag}), 0);
      t = 0; mqp = 0; mqm = 0; err_vis = 0; prev_ra = 0;
    end else begin
      tdone = ndig * PER + 1;
      ra = 0; ed = 0; es = 0; co = 0; qv = 0; bz = 0; dn = 0;
      dp = 0; dm = 0; eqp = mqp; eqm = mqm; ovf = 0; p = -1; j = 0;
      err_next = SAT ? 0 : err_vis;
      if (t > 0 && t < tdone) begin
        bz = 1;
        p = (t - 1) % PER;
        j = (t - 1) / PER;
        if (p == 0) begin
          qv = 1;
          est = int'(res_p) - int'(res_m);
          ovf = (est >= 48 || est <= -48) ? 1 : 0;
          eqp = (est >= 8) ? 1 : 0;
          eqm = (est < -8) ? 1 : 0;
          if (!SAT && ovf == 1) begin
            eqp = 0; eqm = 0;
          end
        end else if (p < C) begin
          ra = p - 1; ed = 1; es = 1; co = (p > 1) ? 1 : 0;
        end else begin
          ra = C - 1; ed = 2; es = 2; co = 1;
        end
        if (ed != 0) begin
          if (mqp == 1) begin
            dp = int'(div_m); dm = int'(div_p);
          end else if (mqm == 1) begin
            dp = int'(div_p); dm = int'(div_m);
          end
        end
      end else if (t > 0 && t == tdone) begin
        dn = 1;
      end

      chk("read_addr", int'(read_addr), ra);
      chk("div_addr", int'(div_addr), ra);
      chk("write_addr", int'(write_addr), prev_ra);
      chk("enable_d", int'(enable_d), ed);
      chk("en_shift", int'(en_shift), es);
      chk("enable_cout", int'(enable_cout), co);
      chk("q_valid", int'(q_valid), qv);
      chk("q_plus", int'(q_plus), eqp);
      chk("q_minus", int'(q_minus), eqm);
      chk("d_plus", int'(d_plus_vec), dp);
      chk("d_minus", int'(d_minus_vec), dm);
      chk("busy", int'(busy), bz);
      chk("done", int'(done), dn);
      chk("error_flag", int'(error_flag), err_vis);

      if (pin_en && p == 0) begin
        chk("pin_q_plus", int'(q_plus), pin_qp);
        chk("pin_q_minus", int'(q_minus), pin_qm);
      end
      if (pin_en && ed != 0) begin
        chk("pin_d_plus", int'(d_plus_vec), pin_dp);
        chk("pin_d_minus", int'(d_minus_vec), pin_dm);
      end

      if (q_valid) dqv++;
      if (done) begin
        chk("latency", cyc - start_cyc,
            pin_en ? pin_lat : ndig * PER + 1);
        chk("digits", dqv, pin_en ? pin_ndig : ndig);
      end

      if (p == 0) begin
        mqp = eqp; mqm = eqm;
        err_next = SAT ? ovf : (err_vis | ovf);
        if (!SAT && ovf == 1) ndig = j + 1;
      end
      prev_ra = ra;
      tdone = ndig * PER + 1;
      if (t == 0) begin
        if (start) begin
          t = 1; ndig = IT; start_cyc = cyc; dqv = 0;
          err_next = 0;
        end
      end else if (t == tdone) begin
        t = 0;
      end else begin
        t++;
      end
      err_vis = err_next;
    end
  end

  task automatic step(input bit s);
    @(posedge clk);
    #1;
    start = s;
    if (rnd) begin
      res_p = UB'($urandom_range(0, lim));
      res_m = UB'($urandom_range(0, lim));
      div_p = UNR'($urandom);
      div_m = UNR'($urandom);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic directed(input int rp, input int rm, input int dvp,
                          input int dvm, input int qp, input int qm,
                          input int dp, input int dm, input int nd,
                          input int lat);
    rnd = 1'b0;
    res_p = UB'(rp); res_m = UB'(rm);
    div_p = UNR'(dvp); div_m = UNR'(dvm);
    pin_qp = qp; pin_qm = qm; pin_dp = dp; pin_dm = dm;
    pin_ndig = nd; pin_lat = lat; pin_en = 1'b1;
    step(1'b1);
    run(IT * PER + 6);
    pin_en = 1'b0;
  endtask

  initial begin
    #1 async_clear_n = 1'b0;
    #22 async_clear_n = 1'b1;
    run(3);

    // est=12 with start held high mid-division
    rnd = 1'b0;
    res_p = 6'd12; res_m = 6'd0; div_p = 4'hA; div_m = 4'h1;
    pin_qp = 1; pin_qm = 0; pin_dp = 4'h1; pin_dm = 4'hA;
    pin_ndig = 32; pin_lat = 289; pin_en = 1'b1;
    step(1'b1);
    run(10);
    repeat (5) step(1'b1);
    run(290);
    pin_en = 1'b0;

    directed(0, 9, 5, 3, 0, 1, 5, 3, 32, 289);
    directed(8, 0, 6, 9, 1, 0, 9, 6, 32, 289);
    directed(0, 8, 6, 9, 0, 0, 0, 0, 32, 289);
    if (SAT) directed(50, 0, 10, 1, 1, 0, 1, 10, 32, 289);
    else directed(50, 0, 10, 1, 0, 0, 0, 0, 1, 10);

    rnd = 1'b1;
    lim = 40;
    repeat (2) begin
      step(1'b1);
      run(IT * PER + 4);
    end
    lim = 63;
    repeat (2) begin
      step(1'b1);
      run(IT * PER + 4);
    end

    // asynchronous clear in the middle of a stream
    lim = 40;
    step(1'b1);
    run(3);
    @(posedge clk);
    #2 async_clear_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 async_clear_n = 1'b1;
    run(5);
    step(1'b1);
    run(IT * PER + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
